dcache_stage: RTL and testbench



---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_array.sv | 66 ++++++
 rtl/dcache_stage.sv | 189 ++++++++++++++++++
 tb/tb_dcache_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the data-cache pipeline stage.
//   state_t   : miss-handling FSM states (IDLE, WBACK, FILL)
//   LDST_*    : ldSt_enable encodings (pass-through, load, store)
//   *_bits()  : address-split width helpers (byte-in-word, offset, index, tag)
package dcache_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WBACK = 2'd1,
      S_FILL  = 2'd2
   } state_t;

   localparam logic [1:0] LDST_PASS  = 2'b00;
   localparam logic [1:0] LDST_LOAD  = 2'b01;
   localparam logic [1:0] LDST_STORE = 2'b10;

   function automatic int unsigned byte_bits(input int unsigned data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic int unsigned off_bits(input int unsigned words);
      return $clog2(words);
   endfunction

   function automatic int unsigned idx_bits(input int unsigned lines);
      return $clog2(lines);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned addr_w, input int unsigned data_w,
                                            input int unsigned lines, input int unsigned words);
      return addr_w - byte_bits(data_w) - off_bits(words) - idx_bits(lines);
   endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped tag/valid/dirty/data storage.
//   index            : line selected for both read and write
//   rd_*             : combinational read of the selected line
//   line_we/line_*   : whole-line fill (valid=1, dirty=0, tag replaced)
//   word_we/word_*   : single-word store into the selected line (dirty=1)
// Only valid and dirty bits are reset; tag/data are qualified by valid.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LINES  = 4,
   parameter int unsigned WORDS  = 8,
   parameter int unsigned TAG_W  = 10,
   localparam int unsigned IDX_W  = idx_bits(LINES),
   localparam int unsigned OFF_W  = off_bits(WORDS),
   localparam int unsigned LINE_W = DATA_W * WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  index,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [LINE_W-1:0] rd_line,
   input  logic              line_we,
   input  logic [TAG_W-1:0]  line_tag,
   input  logic [LINE_W-1:0] line_data,
   input  logic              word_we,
   input  logic [OFF_W-1:0]  word_off,
   input  logic [DATA_W-1:0] word_data
);

   logic [TAG_W-1:0]  tag_q   [LINES];
   logic [LINE_W-1:0] data_q  [LINES];
   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  dirty_q;

   assign rd_tag   = tag_q[index];
   assign rd_valid = valid_q[index];
   assign rd_dirty = dirty_q[index];
   assign rd_line  = data_q[index];

   // Line status bits
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (word_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data storage
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[index]  <= line_tag;
         data_q[index] <= line_data;
      end else if (word_we) begin
         data_q[index][32'(word_off) * DATA_W +: DATA_W] <= word_data;
      end
   end

endmodule

// File: rtl/dcache_stage.sv
// dcache_stage: pipeline data-cache stage, direct-mapped, write-back.
//   clk, reset         : clock, synchronous active-high reset
//   enable_cache, flush: pipeline advance and kill
//   tlb_result, dataReg, ldSt_enable, side_in : request captured into the stage
//   cache_result, side_out, valid_out, stall  : lookup result for the held request
//   mem_*              : line-granular memory port (write-back / fill)
// Optional macro DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module dcache_stage
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINES  = 4,
   parameter int unsigned WORDS  = 8,
   parameter int unsigned SIDE_W = 25
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable_cache,
   input  logic                     flush,
   input  logic [ADDR_W-1:0]        tlb_result,
   input  logic [DATA_W-1:0]        dataReg,
   input  logic [1:0]               ldSt_enable,
   input  logic [SIDE_W-1:0]        side_in,
   output logic [DATA_W-1:0]        cache_result,
   output logic [SIDE_W-1:0]        side_out,
   output logic                     valid_out,
   output logic                     stall,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W*WORDS-1:0]  mem_wdata,
   input  logic                     mem_ready,
   input  logic [DATA_W*WORDS-1:0]  mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
`endif
);

   localparam int unsigned BYTE_W = byte_bits(DATA_W);
   localparam int unsigned OFF_W  = off_bits(WORDS);
   localparam int unsigned IDX_W  = idx_bits(LINES);
   localparam int unsigned TAG_W  = tag_bits(ADDR_W, DATA_W, LINES, WORDS);
   localparam int unsigned LOW_W  = OFF_W + BYTE_W;
   localparam int unsigned LINE_W = DATA_W * WORDS;

   state_t state_q, state_d;

   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [1:0]        req_op;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [OFF_W-1:0]  req_off;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid, rd_dirty;
   logic [LINE_W-1:0] rd_line;

   logic is_load, is_store, hit, miss, capture, line_we, word_we;

   assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
   assign req_idx  = req_addr[LOW_W +: IDX_W];
   assign req_off  = req_addr[BYTE_W +: OFF_W];
   assign is_load  = req_valid && (req_op == LDST_LOAD);
   assign is_store = req_valid && (req_op == LDST_STORE);
   assign hit      = rd_valid && (rd_tag == req_tag);
   assign miss     = (is_load || is_store) && !hit;
   assign stall    = (state_q != S_IDLE) || miss;
   assign capture  = enable_cache && !stall && !flush;
   assign line_we  = (state_q == S_FILL) && mem_ready;
   assign word_we  = (state_q == S_IDLE) && is_store && hit && !flush;

   dcache_array #(
      .DATA_W (DATA_W),
      .LINES  (LINES),
      .WORDS  (WORDS),
      .TAG_W  (TAG_W)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .index     (req_idx),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_line   (rd_line),
      .line_we   (line_we),
      .line_tag  (req_tag),
      .line_data (mem_rdata),
      .word_we   (word_we),
      .word_off  (req_off),
      .word_data (req_data)
   );

   // Request register; flush drops the request but keeps its address so an
   // in-flight write-back/fill still targets the right line.
   always_ff @(posedge clk) begin
      if (reset) begin
         req_valid <= 1'b0;
         req_addr  <= '0;
         req_data  <= '0;
         req_op    <= LDST_PASS;
         side_out  <= '0;
      end else if (flush) begin
         req_valid <= 1'b0;
         req_op    <= LDST_PASS;
      end else if (capture) begin
         req_valid <= 1'b1;
         req_addr  <= tlb_result;
         req_data  <= dataReg;
         req_op    <= ldSt_enable;
         side_out  <= side_in;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (miss && !flush) state_d = rd_valid && rd_dirty ? S_WBACK : S_FILL;
         S_WBACK: if (mem_ready) state_d = S_FILL;
         S_FILL:  if (mem_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; address/data come from held state so they stay stable
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_WBACK: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'({rd_tag, req_idx, LOW_W'(0)});
            mem_wdata = rd_line;
         end
         S_FILL: begin
            mem_req  = 1'b1;
            mem_addr = ADDR_W'({req_tag, req_idx, LOW_W'(0)});
         end
         default: ;
      endcase
   end

   // Result for the held request
   always_comb begin
      valid_out    = 1'b0;
      cache_result = '0;
      if (req_valid && !stall) begin
         valid_out = 1'b1;
         if (is_load) cache_result = rd_line[32'(req_off) * DATA_W +: DATA_W];
         else         cache_result = DATA_W'(req_addr);
      end
   end

`ifdef DCACHE_STATS_EN
   logic counted_q;
   logic lookup_evt;

   // Each request is classified once, on its first lookup
   assign lookup_evt = (state_q == S_IDLE) && (is_load || is_store) && !counted_q && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
         counted_q  <= 1'b0;
      end else begin
         if (lookup_evt && hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
         if (lookup_evt && !hit && (miss_count != '1)) miss_count <= miss_count + 32'd1;
         if (capture)         counted_q <= 1'b0;
         else if (lookup_evt) counted_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_stage.sv
// tb_dcache_stage: directed self-checking bench for dcache_stage (default parameters).
module tb_dcache_stage;

   localparam int unsigned LINE_W = 128;

   logic              clk = 1'b0;
   logic              reset;
   logic              enable_cache;
   logic              flush;
   logic [15:0]       tlb_result;
   logic [15:0]       dataReg;
   logic [1:0]        ldSt_enable;
   logic [24:0]       side_in;
   logic [15:0]       cache_result;
   logic [24:0]       side_out;
   logic              valid_out;
   logic              stall;
   logic              mem_req;
   logic              mem_we;
   logic [15:0]       mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [LINE_W-1:0] mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;
`endif

   int checks = 0;
   int errors = 0;

   dcache_stage dut (
      .clk          (clk),
      .reset        (reset),
      .enable_cache (enable_cache),
      .flush        (flush),
      .tlb_result   (tlb_result),
      .dataReg      (dataReg),
      .ldSt_enable  (ldSt_enable),
      .side_in      (side_in),
      .cache_result (cache_result),
      .side_out     (side_out),
      .valid_out    (valid_out),
      .stall        (stall),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   always #5 clk = ~clk;

   // Line whose word i holds base+i
   function automatic logic [LINE_W-1:0] make_line(input logic [15:0] base);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < 8; i++) l[i*16 +: 16] = base + 16'(i);
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request for exactly one capture edge
   task automatic issue(input logic [15:0] a, input logic [15:0] d, input logic [1:0] op,
                        input logic [24:0] s);
      tlb_result   = a;
      dataReg      = d;
      ldSt_enable  = op;
      side_in      = s;
      enable_cache = 1'b1;
      tick();
      enable_cache = 1'b0;
   endtask

   // Return a line to an outstanding request in the current cycle
   task automatic respond(input logic [LINE_W-1:0] line);
      mem_ready = 1'b1;
      mem_rdata = line;
      tick();
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", valid_out); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0h exp=0", stall); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem got=%0h%0h exp=00", mem_req, mem_we); end
      checks++; if (cache_result !== 16'h0 || side_out !== 25'h0) begin errors++; $display("FAIL rst_data got=%0h/%0h exp=0/0", cache_result, side_out); end
`ifdef DCACHE_STATS_EN
      checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
      reset = 1'b0;
   endtask

   task automatic test_load_miss();
      issue(16'h0010, 16'h0, 2'b01, 25'h1ABCDE);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lm_stall got=%0h exp=1", stall); end
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lm_valid got=%0h exp=0", valid_out); end
      checks++; if (side_out !== 25'h1ABCDE) begin errors++; $display("FAIL lm_side got=%0h exp=1abcde", side_out); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin errors++; $display("FAIL lm_fill got=%0h/%0h/%0h exp=1/0/10", mem_req, mem_we, mem_addr); end
      tick();
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || stall !== 1'b1) begin errors++; $display("FAIL lm_hold got=%0h/%0h/%0h exp=1/10/1", mem_req, mem_addr, stall); end
      respond(make_line(16'h1000));
      checks++; if (valid_out !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL lm_done got=%0h/%0h exp=1/0", valid_out, stall); end
      checks++; if (cache_result !== 16'h1000) begin errors++; $display("FAIL lm_data got=%0h exp=1000", cache_result); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL lm_idle got=%0h exp=0", mem_req); end
   endtask

   task automatic test_store_hit();
      issue(16'h0012, 16'hBEEF, 2'b10, 25'h5);
      checks++; if (stall !== 1'b0 || valid_out !== 1'b1) begin errors++; $display("FAIL st_hit got=%0h/%0h exp=0/1", stall, valid_out); end
      checks++; if (cache_result !== 16'h0012) begin errors++; $display("FAIL st_result got=%0h exp=12", cache_result); end
      issue(16'h0012, 16'h0, 2'b01, 25'h6);
      checks++; if (valid_out !== 1'b1 || cache_result !== 16'hBEEF) begin errors++; $display("FAIL st_readback got=%0h/%0h exp=1/beef", valid_out, cache_result); end
   endtask

   task automatic test_wback();
      logic [LINE_W-1:0] victim;
      victim = make_line(16'h1000);
      victim[16 +: 16] = 16'hBEEF;
      issue(16'h0090, 16'h0, 2'b01, 25'h7);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL wb_stall got=%0h exp=1", stall); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("FAIL wb_cmd got=%0h/%0h/%0h exp=1/1/10", mem_req, mem_we, mem_addr); end
      checks++; if (mem_wdata !== victim) begin errors++; $display("FAIL wb_data got=%0h exp=%0h", mem_wdata, victim); end
      tick();
      checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== victim) begin errors++; $display("FAIL wb_hold got=%0h/%0h exp=1/10", mem_we, mem_addr); end
      respond('0);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0090) begin errors++; $display("FAIL wb_fill got=%0h/%0h/%0h exp=1/0/90", mem_req, mem_we, mem_addr); end
      respond(make_line(16'h9000));
      checks++; if (valid_out !== 1'b1 || cache_result !== 16'h9000) begin errors++; $display("FAIL wb_done got=%0h/%0h exp=1/9000", valid_out, cache_result); end
`ifdef DCACHE_STATS_EN
      checks++; if (hit_count !== 32'd2 || miss_count !== 32'd2) begin errors++; $display("FAIL stats got=%0d/%0d exp=2/2", hit_count, miss_count); end
`endif
   endtask

   task automatic test_flush();
      // Evict 0x0090 with a clean fill so it can miss again
      issue(16'h0110, 16'h0, 2'b01, 25'h8);
      tick();
      checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0110) begin errors++; $display("FAIL fl_clean got=%0h/%0h exp=0/110", mem_we, mem_addr); end
      respond(make_line(16'h4400));
      checks++; if (cache_result !== 16'h4400) begin errors++; $display("FAIL fl_evict got=%0h exp=4400", cache_result); end
      issue(16'h0090, 16'h0, 2'b01, 25'h9);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (mem_req !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL fl_inflight got=%0h/%0h exp=1/0", mem_req, valid_out); end
      respond(make_line(16'h9A00));
      checks++; if (valid_out !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fl_discard got=%0h/%0h/%0h exp=0/0/0", valid_out, stall, mem_req); end
      issue(16'h0090, 16'h0, 2'b01, 25'hA);
      checks++; if (stall !== 1'b0 || valid_out !== 1'b1 || cache_result !== 16'h9A00) begin errors++; $display("FAIL fl_hit got=%0h/%0h/%0h exp=0/1/9a00", stall, valid_out, cache_result); end
      issue(16'h1234, 16'h0, 2'b00, 25'h7);
      checks++; if (valid_out !== 1'b1 || cache_result !== 16'h1234 || side_out !== 25'h7) begin errors++; $display("FAIL pass got=%0h/%0h/%0h exp=1/1234/7", valid_out, cache_result, side_out); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (valid_out !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL fl_idle got=%0h/%0h exp=0/0", valid_out, stall); end
   endtask

   task automatic test_reset_wback();
      issue(16'h0092, 16'h5555, 2'b10, 25'h1);
      checks++; if (valid_out !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rw_store got=%0h/%0h exp=1/0", valid_out, stall); end
      issue(16'h0010, 16'h0, 2'b01, 25'h2);
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0090) begin errors++; $display("FAIL rw_wback got=%0h/%0h/%0h exp=1/1/90", mem_req, mem_we, mem_addr); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (mem_req !== 1'b0 || valid_out !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rw_abort got=%0h/%0h/%0h exp=0/0/0", mem_req, valid_out, stall); end
      issue(16'h0010, 16'h0, 2'b01, 25'h3);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_miss got=%0h exp=1", stall); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin errors++; $display("FAIL rw_fill got=%0h/%0h/%0h exp=1/0/10", mem_req, mem_we, mem_addr); end
      respond(make_line(16'h1000));
      checks++; if (valid_out !== 1'b1 || cache_result !== 16'h1000) begin errors++; $display("FAIL rw_done got=%0h/%0h exp=1/1000", valid_out, cache_result); end
   endtask

   initial begin
      reset        = 1'b1;
      enable_cache = 1'b0;
      flush        = 1'b0;
      tlb_result   = '0;
      dataReg      = '0;
      ldSt_enable  = 2'b00;
      side_in      = '0;
      mem_ready    = 1'b0;
      mem_rdata    = '0;
      test_reset();
      test_load_miss();
      test_store_hit();
      test_wback();
      test_flush();
      test_reset_wback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
